mmi_mod_tmr: RTL
================

# mmi_mod_tmr

MMIO timer block driven by the single-cycle tick pulses of the clock pulser (`timer1MHz`, `timer1kHz`). Holds a free-running 64-bit microsecond counter and one programmable 32-bit countdown timer with one-shot/periodic modes and a level interrupt. Sits between the clock pulser and the MMIO bus, and supplies the timer IRQ line to the interrupt controller.

## Interface
Parameters:
- `CNT_W`, 32: countdown/reload width; fixed at 32 for this revision.

Ports:
- `clock`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `timer1MHz`  in  1  1 MHz tick, one clock wide.
- `timer1kHz`  in  1  1 kHz tick, one clock wide.
- `regAddr`  in  3  register word index.
- `regDataIn`  in  32  write data.
- `regWr`  in  1  write strobe, one cycle.
- `regRd`  in  1  read strobe, one cycle.
- `regDataOut`  out  32  read data, valid while `regOK`.
- `regOK`  out  1  access acknowledge.
- `irqTimer`  out  1  level interrupt = `STATUS.EXP & CTRL.IE`.

## Operation
- Register map:
  - 0 `USEC_LO` (RO). A read also latches `usec[63:32]` into a shadow register.
  - 1 `USEC_HI` (RO). Returns the shadow register.
  - 2 `CTRL` (RW): bit0 EN, bit1 PER (periodic), bit2 SRC (0 = 1 MHz, 1 = 1 kHz), bit3 IE. Other bits read 0.
  - 3 `RELOAD` (RW).
  - 4 `COUNT`: read returns the live count; write loads the count.
  - 5 `STATUS`: bit0 EXP; writing 1 clears it.
  - 6–7: read 0, writes ignored, still acknowledged.
- `usec` increments by 1 on every `timer1MHz`, independent of CTRL, and wraps 2^64−1 → 0.
- The selected tick is `tick = SRC ? timer1kHz : timer1MHz`.
- Countdown states:
  - **IDLE** (EN=0): COUNT holds its value.
  - **RUN**: entered on a CTRL write that sets EN. If COUNT==0 at that moment, COUNT ← RELOAD.
  - In RUN, on each `tick`:
    - COUNT>1: COUNT−1.
    - COUNT≤1: expiry. EXP ← 1.
      - PER=1: COUNT ← RELOAD; if RELOAD==0, COUNT ← 1, so expiry fires on every tick.
      - PER=0: COUNT ← 0, EN ← 0, return to IDLE.
  - A CTRL write clearing EN returns to IDLE immediately; COUNT is preserved.
- Collision rules:
  - A COUNT write in the same cycle as a `tick` takes priority; that tick is dropped.
  - STATUS write-1-clear in the same cycle as an expiry: expiry wins and EXP stays 1.
  - `regRd` and `regWr` both asserted: treated as a write; `regDataOut` = 0.
  - A `USEC_LO` read coinciding with an increment returns the pre-increment value, and the shadow holds the matching pre-increment high word.

## Timing
- Reset values: all registers 0; `regDataOut`=0, `regOK`=0, `irqTimer`=0, state IDLE.
- Reset is asynchronous and may assert mid-count or mid-access. Outputs drop to 0 immediately; no acknowledge is issued for the aborted access.
- Access latency is 1:
  - A strobe sampled at edge N gives `regOK`=1 and valid `regDataOut` for one cycle after edge N.
  - Write effects are visible after edge N.
  - `regDataOut` is 0 when `regOK`=0.
- Strobes on back-to-back cycles are each acknowledged. There is no backpressure.
- Tick → effect:
  - `tick` sampled at edge N updates COUNT and EXP after edge N.
  - `irqTimer` is registered and follows EXP & IE, becoming valid after edge N.
- `usec` increments after the edge that samples `timer1MHz`.

## Test plan
- **Reset and usec:**
  - Assert reset mid-run: all outputs go 0 asynchronously.
  - Release reset and give 5 `timer1MHz` pulses: `USEC_LO`=5 and `USEC_HI`=0, each acknowledged one cycle after its strobe.
- **One-shot:**
  - Setup: RELOAD=3, COUNT=0, CTRL=EN|IE.
  - After 3 `timer1MHz` ticks: COUNT=0, EXP=1, `irqTimer`=1, EN reads 0.
  - Write STATUS=1: `irqTimer`=0.
- **Periodic, 1 kHz source:**
  - Setup: RELOAD=2, CTRL=EN|PER|SRC|IE.
  - After 6 `timer1kHz` ticks: EXP has been set at ticks 2, 4 and 6, and COUNT=2.
  - `timer1MHz` pulses in between leave COUNT unchanged.
- **Collisions:**
  - COUNT write of 10 on the same cycle as a tick: COUNT reads 10.
  - STATUS clear on the same cycle as an expiry: EXP stays 1.
- **usec wrap and shadow:**
  - Preload `usec` to 0x0000_0000_FFFF_FFFF by force.
  - Read `USEC_LO` in the same cycle as a tick: returns 0xFFFF_FFFF.
  - The following `USEC_HI` read returns 0.
  - A second `USEC_LO` read, then `USEC_HI`, returns 1.
- **Unmapped and dual strobe:**
  - Read address 7: `regDataOut`=0, `regOK`=1.
  - `regRd`+`regWr` to RELOAD with 0x55: RELOAD=0x55, `regDataOut`=0.

Source files
------------

// File: rtl/mmi_mod_tmr.sv
// mmi_mod_tmr -- MMIO timer block.
//
// Holds a free-running 64-bit microsecond counter (advanced by timer1MHz) and
// one 32-bit countdown timer with one-shot / periodic modes and a level IRQ.
//
// Ports:
//   clock      in   core clock
//   reset      in   asynchronous active-high reset, clears all state
//   timer1MHz  in   1 MHz tick, one clock wide
//   timer1kHz  in   1 kHz tick, one clock wide
//   regAddr    in   [2:0]  register word index
//   regDataIn  in   [31:0] write data
//   regWr      in   write strobe
//   regRd      in   read strobe
//   regDataOut out  [31:0] read data, valid while regOK (0 otherwise)
//   regOK      out  access acknowledge, one cycle after the strobe
//   irqTimer   out  registered STATUS.EXP & CTRL.IE
//
// Register map: 0 USEC_LO, 1 USEC_HI (shadow), 2 CTRL {IE,SRC,PER,EN},
//               3 RELOAD, 4 COUNT, 5 STATUS {EXP}, 6-7 read as 0.
module mmi_mod_tmr #(
  parameter int CNT_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        timer1MHz,
  input  logic        timer1kHz,
  input  logic [2:0]  regAddr,
  input  logic [31:0] regDataIn,
  input  logic        regWr,
  input  logic        regRd,
  output logic [31:0] regDataOut,
  output logic        regOK,
  output logic        irqTimer
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             r_state;
  logic [63:0]        r_usec;
  logic [31:0]        r_usec_shadow;
  logic               r_per;
  logic               r_src;
  logic               r_ie;
  logic [CNT_W-1:0]   r_reload;
  logic [CNT_W-1:0]   r_count;
  logic               r_exp;
  logic               r_irq;
  logic               r_ok;
  logic [31:0]        r_dout;

  state_t             w_state_next;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_exp_next;
  logic               w_ie_next;
  logic [31:0]        w_rdata;
  logic               w_rd;
  logic               w_ctrl_wr;
  logic               w_reload_wr;
  logic               w_count_wr;
  logic               w_status_wr;
  logic               w_tick;
  logic               w_run_tick;
  logic               w_expire;

  // A simultaneous read and write is handled purely as a write.
  assign w_rd        = regRd & ~regWr;
  assign w_ctrl_wr   = regWr & (regAddr == 3'd2);
  assign w_reload_wr = regWr & (regAddr == 3'd3);
  assign w_count_wr  = regWr & (regAddr == 3'd4);
  assign w_status_wr = regWr & (regAddr == 3'd5);

  assign w_tick   = r_src ? timer1kHz : timer1MHz;
  // A register write to COUNT or CTRL in the tick cycle swallows the tick.
  assign w_run_tick = (r_state == ST_RUN) & w_tick & ~w_count_wr & ~w_ctrl_wr;
  assign w_expire   = (r_count <= CNT_W'(1));

  assign w_ie_next = w_ctrl_wr ? regDataIn[3] : r_ie;

  // State register plus all other sequential state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_usec        <= 64'd0;
      r_usec_shadow <= 32'd0;
      r_per         <= 1'b0;
      r_src         <= 1'b0;
      r_ie          <= 1'b0;
      r_reload      <= '0;
      r_count       <= '0;
      r_exp         <= 1'b0;
      r_irq         <= 1'b0;
      r_ok          <= 1'b0;
      r_dout        <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_exp   <= w_exp_next;
      r_ie    <= w_ie_next;
      r_irq   <= w_exp_next & w_ie_next;
      if (w_ctrl_wr) begin
        r_per <= regDataIn[1];
        r_src <= regDataIn[2];
      end
      if (w_reload_wr) begin
        r_reload <= regDataIn[CNT_W-1:0];
      end
      if (timer1MHz) begin
        r_usec <= r_usec + 64'd1;
      end
      // Shadow captures the pre-increment high word so LO/HI stay coherent.
      if (w_rd && (regAddr == 3'd0)) begin
        r_usec_shadow <= r_usec[63:32];
      end
      r_ok   <= regRd | regWr;
      r_dout <= w_rd ? w_rdata : 32'd0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    if (w_ctrl_wr) begin
      w_state_next = regDataIn[0] ? ST_RUN : ST_IDLE;
    end else if (w_run_tick && w_expire && !r_per) begin
      w_state_next = ST_IDLE;
    end
  end

  // Datapath / output logic.
  always_comb begin
    w_count_next = r_count;
    w_exp_next   = r_exp;
    if (w_count_wr) begin
      w_count_next = regDataIn[CNT_W-1:0];
    end else if (w_ctrl_wr && regDataIn[0] && (r_state == ST_IDLE)
                 && (r_count == '0)) begin
      w_count_next = r_reload;
    end else if (w_run_tick) begin
      if (!w_expire) begin
        w_count_next = r_count - CNT_W'(1);
      end else if (r_per) begin
        // A zero reload parks at 1 so every tick expires.
        w_count_next = (r_reload == '0) ? CNT_W'(1) : r_reload;
      end else begin
        w_count_next = '0;
      end
    end

    // Expiry beats a same-cycle write-1-clear.
    if (w_run_tick && w_expire) begin
      w_exp_next = 1'b1;
    end else if (w_status_wr && regDataIn[0]) begin
      w_exp_next = 1'b0;
    end

    w_rdata = 32'd0;
    case (regAddr)
      3'd0: w_rdata = r_usec[31:0];
      3'd1: w_rdata = r_usec_shadow;
      3'd2: w_rdata = {28'd0, r_ie, r_src, r_per, (r_state == ST_RUN)};
      3'd3: w_rdata = r_reload;
      3'd4: w_rdata = r_count;
      3'd5: w_rdata = {31'd0, r_exp};
      default: w_rdata = 32'd0;
    endcase
  end

  assign regDataOut = r_dout;
  assign regOK      = r_ok;
  assign irqTimer   = r_irq;

endmodule
